// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve / next-PC predictor update path.
package branch_resolve_pkg;
  localparam int PC_W  = 13;
  localparam int CNT_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    logic v;
    pc_t  pc;
    pc_t  pred;
  } stage_t;

  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK) begin
    if (!RSTN)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/branch_resolve.sv
// Carries fetched PCs and predictions through F->D->E, resolves the real next PC
// and raises single-cycle mispredict/flush pulses toward the next-PC predictor.
module branch_resolve #(
  parameter int CNT_W = branch_resolve_pkg::CNT_W
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic                              stall,
  input  logic [branch_resolve_pkg::PC_W-1:0] pcF,
  input  logic                              hit_predict,
  input  logic [branch_resolve_pkg::PC_W-1:0] prepc,
  input  logic                              is_jalD,
  input  logic                              is_ctrlD,
  input  logic [branch_resolve_pkg::PC_W-1:0] immD,
  input  logic                              resolveE,
  input  logic                              takenE,
  input  logic [branch_resolve_pkg::PC_W-1:0] targetE,
  output logic [branch_resolve_pkg::PC_W-1:0] pcD,
  output logic [branch_resolve_pkg::PC_W-1:0] nextpcD,
  output logic                              fail_predictD,
  output logic [branch_resolve_pkg::PC_W-1:0] pcE,
  output logic [branch_resolve_pkg::PC_W-1:0] nextpcE,
  output logic                              fail_predictE,
  output logic                              flushD,
  output logic                              flushE,
  output logic [CNT_W-1:0]                  n_ctrl,
  output logic [CNT_W-1:0]                  n_miss
);
  import branch_resolve_pkg::*;

  stage_t fd, de;
  pc_t    predF, actD, actE;
  logic   rawD, ctrl_ev;

  always_comb begin
    predF = hit_predict ? prepc : pc_inc(pcF);
    actD  = is_jalD ? fd.pc + immD : pc_inc(fd.pc);
    actE  = takenE ? targetE : pc_inc(de.pc);
    rawD  = fd.v & ~is_ctrlD & (actD != fd.pred);
    // E is older, so its redirect wins; D stays quiet so the predictor sees one update
    fail_predictE = de.v & resolveE & (actE != de.pred) & ~stall;
    fail_predictD = rawD & ~fail_predictE & ~stall;
    flushD  = fail_predictD | fail_predictE;
    flushE  = fail_predictE;
    ctrl_ev = ~stall & ((de.v & resolveE) | (fd.v & is_jalD & ~fail_predictE));
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      fd <= '0;
      de <= '0;
    end else if (!stall) begin
      fd <= '{v: ~flushD, pc: pcF, pred: predF};
      // a D-only miss lets the JAL itself advance into E
      de <= '{v: fd.v & ~flushE, pc: fd.pc, pred: fd.pred};
    end
  end

  assign pcD     = fd.pc;
  assign nextpcD = actD;
  assign pcE     = de.pc;
  assign nextpcE = actE;

  sat_counter #(.W(CNT_W)) u_ctrl_cnt (
    .CLK (CLK),
    .RSTN(RSTN),
    .inc (ctrl_ev),
    .cnt (n_ctrl)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .CLK (CLK),
    .RSTN(RSTN),
    .inc (fail_predictD | fail_predictE),
    .cnt (n_miss)
  );
endmodule
